// File: rtl/gray_counter_n_if.sv
`default_nettype none
// ============================================================================
// Module      : gray_counter_n_if
// Description : Control/status bundle for gray_counter_n. The master side
//               drives enable, direction, load and flag-clear; the slave side
//               (the counter) returns the Gray count and status flags.
//               BinOut exists only when GRAY_CNT_BIN_OUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface gray_counter_n_if #(
    parameter int WIDTH = 3
);
    logic             En;
    logic             Dir;
    logic             Load;
    logic [WIDTH-1:0] LoadVal;
    logic             ClrFlags;
    logic [WIDTH-1:0] Output;
    logic             Overflow;
    logic             Underflow;
    logic             Wrap;
`ifdef GRAY_CNT_BIN_OUT_EN
    logic [WIDTH-1:0] BinOut;
`endif

    modport master (
        output En, Dir, Load, LoadVal, ClrFlags,
`ifdef GRAY_CNT_BIN_OUT_EN
        input  BinOut,
`endif
        input  Output, Overflow, Underflow, Wrap
    );

    modport slave (
        input  En, Dir, Load, LoadVal, ClrFlags,
`ifdef GRAY_CNT_BIN_OUT_EN
        output BinOut,
`endif
        output Output, Overflow, Underflow, Wrap
    );
endinterface
`default_nettype wire

// File: rtl/gray_counter_n.sv
`default_nettype none
// ============================================================================
// Module      : gray_counter_n
// Description : Parametrised N-bit Gray-code counter with up/down counting,
//               parallel Gray-encoded load, wrap or saturate mode, sticky
//               overflow/underflow flags and a one-cycle Wrap pulse.
//               Optional macro GRAY_CNT_BIN_OUT_EN adds a registered binary
//               copy of the count on BinOut.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_counter_n #(
    parameter int WIDTH    = 3,
    parameter bit SATURATE = 1'b0
) (
    input  wire                Clk,
    input  wire                Reset,
    gray_counter_n_if.slave    bus
);

    localparam logic [WIDTH-1:0] c_MAX  = '1;
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             ovf_q,  ovf_d;
    logic             unf_q,  unf_d;
    logic             wrap_q, wrap_d;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Next-state: load beats count; a flag-set event beats ClrFlags for that flag.
    always_comb begin
        bin_d  = bin_q;
        ovf_d  = ovf_q & ~bus.ClrFlags;
        unf_d  = unf_q & ~bus.ClrFlags;
        wrap_d = 1'b0;
        if (bus.Load) begin
            bin_d = gray2bin(bus.LoadVal);
        end else if (bus.En) begin
            if (!bus.Dir) begin
                if (bin_q == c_MAX) begin
                    ovf_d  = 1'b1;
                    wrap_d = 1'b1;
                    bin_d  = SATURATE ? bin_q : c_ZERO;
                end else begin
                    bin_d = bin_q + 1'b1;
                end
            end else begin
                if (bin_q == c_ZERO) begin
                    unf_d  = 1'b1;
                    wrap_d = 1'b1;
                    bin_d  = SATURATE ? bin_q : c_MAX;
                end else begin
                    bin_d = bin_q - 1'b1;
                end
            end
        end
        // Gray output is precomputed so the port is driven straight from a flop.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // State and registered outputs; Reset overrides everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bin_q  <= '0;
            gray_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.Output    = gray_q;
    assign bus.Overflow  = ovf_q;
    assign bus.Underflow = unf_q;
    assign bus.Wrap      = wrap_q;

`ifdef GRAY_CNT_BIN_OUT_EN
    // The binary state register is already aligned with gray_q.
    assign bus.BinOut = bin_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_counter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_counter_n
// Description : Directed bench for gray_counter_n. Three instances: WIDTH=3
//               wrapping (A), WIDTH=3 saturating (B), WIDTH=5 wrapping (C).
//               BinOut is checked on C when GRAY_CNT_BIN_OUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_counter_n;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    int   nerr  = 0;
    int   nchk  = 0;

    always #5 Clk = ~Clk;

    gray_counter_n_if #(.WIDTH(3)) ifa ();
    gray_counter_n_if #(.WIDTH(3)) ifb ();
    gray_counter_n_if #(.WIDTH(5)) ifc ();

    gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) u_a (.Clk(Clk), .Reset(Reset), .bus(ifa));
    gray_counter_n #(.WIDTH(3), .SATURATE(1'b1)) u_b (.Clk(Clk), .Reset(Reset), .bus(ifb));
    gray_counter_n #(.WIDTH(5), .SATURATE(1'b0)) u_c (.Clk(Clk), .Reset(Reset), .bus(ifc));

    logic [2:0] up_seq [8] = '{3'b001, 3'b011, 3'b010, 3'b110,
                               3'b111, 3'b101, 3'b100, 3'b000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [2:0] prev3;
        logic [4:0] prev5;
        logic [4:0] cnt5;

        ifa.En = 0; ifa.Dir = 0; ifa.Load = 0; ifa.LoadVal = 0; ifa.ClrFlags = 0;
        ifb.En = 0; ifb.Dir = 0; ifb.Load = 0; ifb.LoadVal = 0; ifb.ClrFlags = 0;
        ifc.En = 0; ifc.Dir = 0; ifc.Load = 0; ifc.LoadVal = 0; ifc.ClrFlags = 0;

        // ---- Reset state ----
        Reset = 1; tick(); tick();
        chk("rst_out_a",  ifa.Output, 0);
        chk("rst_ovf_a",  ifa.Overflow, 0);
        chk("rst_unf_a",  ifa.Underflow, 0);
        chk("rst_wrap_a", ifa.Wrap, 0);
        chk("rst_out_c",  ifc.Output, 0);
        Reset = 0;

        // ---- A: 8 up-steps through the full sequence ----
        ifa.En = 1; ifa.Dir = 0;
        prev3 = 3'b000;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("up_out_%0d", i), ifa.Output, up_seq[i]);
            chk($sformatf("up_1bit_%0d", i), $countones(prev3 ^ ifa.Output), 1);
            chk($sformatf("up_ovf_%0d", i), ifa.Overflow, (i == 7) ? 1 : 0);
            chk($sformatf("up_wrap_%0d", i), ifa.Wrap, (i == 7) ? 1 : 0);
            prev3 = ifa.Output;
        end
        ifa.En = 0; tick();
        chk("idle_wrap_off", ifa.Wrap, 0);
        chk("idle_ovf_sticky", ifa.Overflow, 1);
        chk("idle_hold", ifa.Output, 3'b000);

        // ---- A: down-step from reset underflows ----
        Reset = 1; tick(); Reset = 0;
        ifa.En = 1; ifa.Dir = 1; tick();
        chk("dn_out", ifa.Output, 3'b100);
        chk("dn_unf", ifa.Underflow, 1);
        chk("dn_ovf", ifa.Overflow, 0);
        chk("dn_wrap", ifa.Wrap, 1);
        ifa.En = 0; ifa.ClrFlags = 1; tick();
        ifa.ClrFlags = 0;
        chk("clr_unf", ifa.Underflow, 0);
        chk("clr_ovf", ifa.Overflow, 0);
        chk("clr_wrap", ifa.Wrap, 0);

        // ---- A: down then up returns to the same value (bin7 -> 6 -> 7) ----
        ifa.En = 1; ifa.Dir = 1; tick();
        chk("ud_down", ifa.Output, 3'b101);
        ifa.Dir = 0; tick();
        chk("ud_up", ifa.Output, 3'b100);
        chk("ud_noflag", ifa.Overflow, 0);

        // ---- A: Load and En together, Load wins ----
        ifa.Load = 1; ifa.En = 1; ifa.LoadVal = 3'b110; tick();
        chk("ld_out", ifa.Output, 3'b110);
        ifa.Load = 0; tick();
        chk("ld_next_up", ifa.Output, 3'b111);

        // ---- A: overflow, load keeps flag but drops Wrap, then Reset overrides ----
        ifa.En = 0; ifa.Load = 1; ifa.LoadVal = 3'b100; tick();
        ifa.Load = 0; ifa.En = 1; tick();
        chk("ov2_out", ifa.Output, 3'b000);
        chk("ov2_ovf", ifa.Overflow, 1);
        ifa.En = 0; ifa.Load = 1; ifa.LoadVal = 3'b101; tick();
        chk("ld101_out", ifa.Output, 3'b101);
        chk("ld101_ovf", ifa.Overflow, 1);
        chk("ld101_wrap", ifa.Wrap, 0);
        Reset = 1; ifa.Load = 1; ifa.En = 1; ifa.LoadVal = 3'b011; tick();
        Reset = 0; ifa.Load = 0; ifa.En = 0;
        chk("rstov_out", ifa.Output, 3'b000);
        chk("rstov_ovf", ifa.Overflow, 0);
        chk("rstov_unf", ifa.Underflow, 0);
        chk("rstov_wrap", ifa.Wrap, 0);

        // ---- A: ClrFlags coincident with overflow: set wins, other clears ----
        ifa.En = 1; ifa.Dir = 1; tick();
        chk("pre_unf", ifa.Underflow, 1);
        ifa.Dir = 0; ifa.ClrFlags = 1; tick();
        ifa.ClrFlags = 0; ifa.En = 0;
        chk("clrset_ovf", ifa.Overflow, 1);
        chk("clrset_unf", ifa.Underflow, 0);
        chk("clrset_out", ifa.Output, 3'b000);

        // ---- B: saturating mode ----
        ifb.Load = 1; ifb.LoadVal = 3'b100; tick();
        ifb.Load = 0;
        chk("sat_ld", ifb.Output, 3'b100);
        ifb.En = 1; ifb.Dir = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("sat_hold_%0d", i), ifb.Output, 3'b100);
        end
        chk("sat_ovf", ifb.Overflow, 1);
        chk("sat_wrap", ifb.Wrap, 1);
        ifb.Dir = 1; tick();
        ifb.En = 0;
        chk("sat_down", ifb.Output, 3'b101);
        chk("sat_down_wrap", ifb.Wrap, 0);

        // ---- C: WIDTH=5, 64 up-steps ----
        Reset = 1; tick(); Reset = 0;
        ifc.En = 1; ifc.Dir = 0;
        prev5 = 5'd0;
        cnt5  = 5'd0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            cnt5 = cnt5 + 5'd1;
            chk($sformatf("c_out_%0d", i), ifc.Output, cnt5 ^ (cnt5 >> 1));
            chk($sformatf("c_1bit_%0d", i), $countones(prev5 ^ ifc.Output), 1);
            chk($sformatf("c_ovf_%0d", i), ifc.Overflow, (i >= 32) ? 1 : 0);
`ifdef GRAY_CNT_BIN_OUT_EN
            chk($sformatf("c_bin_%0d", i), ifc.BinOut, cnt5);
`endif
            prev5 = ifc.Output;
        end
        ifc.En = 0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
